// File: rtl/alarm_controller.sv
// Alarm time store plus ring/snooze/stop sequencer for the wall clock.
// Compares against the running time on each 1 Hz tick and blinks the alarm drive.
module alarm_controller #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [4:0] hour,
    input  logic [5:0] minute,
    input  logic [5:0] second,
    input  logic       set_en,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic       arm,
    input  logic       snooze,
    input  logic       stop,
    output logic       alarm_out,
    output logic       ringing,
    output logic       snoozing,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min
);

    localparam int RW = $clog2(RING_SECS + 1);
    localparam int SW = $clog2(SNOOZE_SECS + 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RINGING,
        SNOOZE
    } state_t;

    state_t        state, state_n;
    logic [RW-1:0] ring_cnt, ring_cnt_n, ring_inc;
    logic [SW-1:0] snooze_cnt, snooze_cnt_n;
    logic          blink, blink_n;
    logic          match, load_ok;

    assign load_ok  = set_en && (set_hour < 5'd24) && (set_min < 6'd60);
    assign match    = tick && (hour == alarm_hour) && (minute == alarm_min)
                      && (second == 6'd0);
    assign ring_inc = ring_cnt + RW'(1);

    always_comb begin
        state_n      = state;
        ring_cnt_n   = ring_cnt;
        snooze_cnt_n = snooze_cnt;
        blink_n      = blink;
        if (!arm) begin
            state_n      = IDLE;
            ring_cnt_n   = '0;
            snooze_cnt_n = '0;
            blink_n      = 1'b0;
        end else begin
            unique case (state)
                IDLE: state_n = ARMED;
                ARMED: begin
                    if (match) begin
                        state_n    = RINGING;
                        ring_cnt_n = '0;
                        blink_n    = 1'b1;
                    end
                end
                RINGING: begin
                    if (stop) begin
                        state_n = ARMED;
                    end else if (snooze) begin
                        state_n      = SNOOZE;
                        snooze_cnt_n = SW'(SNOOZE_SECS);
                    end else if (tick) begin
                        ring_cnt_n = ring_inc;
                        blink_n    = ~blink;
                        if (ring_inc == RW'(RING_SECS))
                            state_n = ARMED;
                    end
                end
                SNOOZE: begin
                    if (stop) begin
                        state_n = ARMED;
                    end else if (tick) begin
                        // Counter stops at 1; the wake-up tick re-enters ringing.
                        if (snooze_cnt == SW'(1)) begin
                            state_n    = RINGING;
                            ring_cnt_n = '0;
                            blink_n    = 1'b1;
                        end else begin
                            snooze_cnt_n = snooze_cnt - SW'(1);
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ring_cnt   <= '0;
            snooze_cnt <= '0;
            blink      <= 1'b0;
            alarm_out  <= 1'b0;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
            alarm_hour <= '0;
            alarm_min  <= '0;
        end else begin
            state      <= state_n;
            ring_cnt   <= ring_cnt_n;
            snooze_cnt <= snooze_cnt_n;
            blink      <= blink_n;
            alarm_out  <= (state_n == RINGING) && blink_n;
            ringing    <= (state_n == RINGING);
            snoozing   <= (state_n == SNOOZE);
            if (load_ok) begin
                alarm_hour <= set_hour;
                alarm_min  <= set_min;
            end
        end
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with a queue of expected output snapshots.
module tb_alarm_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [4:0] hour = '0;
    logic [5:0] minute = '0;
    logic [5:0] second = '0;
    logic       set_en = 1'b0;
    logic [4:0] set_hour = '0;
    logic [5:0] set_min = '0;
    logic       arm = 1'b0;
    logic       snooze = 1'b0;
    logic       stop = 1'b0;
    logic       alarm_out, ringing, snoozing;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;

    typedef struct {
        string       tag;
        logic [13:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails = 0;

    alarm_controller #(.RING_SECS(60), .SNOOZE_SECS(300)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .hour(hour), .minute(minute), .second(second),
        .set_en(set_en), .set_hour(set_hour), .set_min(set_min),
        .arm(arm), .snooze(snooze), .stop(stop),
        .alarm_out(alarm_out), .ringing(ringing), .snoozing(snoozing),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(string tag, logic a, logic r, logic s,
                        logic [4:0] h, logic [5:0] m);
        exp_t e;
        e.tag = tag;
        e.v   = {a, r, s, h, m};
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [13:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = {alarm_out, ringing, snoozing, alarm_hour, alarm_min};
            checks++;
            assert (obs === e.v) else begin
                fails++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
            end
        end
    endtask

    // One clock carrying a tick at the given time, then compare.
    task automatic tk(logic [4:0] th, logic [5:0] tm, logic [5:0] ts,
                      string tag, logic a, logic r, logic s,
                      logic [4:0] h, logic [5:0] m);
        hour = th; minute = tm; second = ts; tick = 1'b1;
        push(tag, a, r, s, h, m);
        cyc();
        tick = 1'b0;
        check();
    endtask

    // One clock with no tick, then compare.
    task automatic idle(string tag, logic a, logic r, logic s,
                        logic [4:0] h, logic [5:0] m);
        push(tag, a, r, s, h, m);
        cyc();
        stop = 1'b0; snooze = 1'b0; set_en = 1'b0;
        check();
    endtask

    initial begin
        cyc();
        idle("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;

        set_en = 1'b1; set_hour = 5'd6; set_min = 6'd30;
        idle("load_0630", 0, 0, 0, 6, 30);

        arm = 1'b1;
        tk(6, 30, 0, "arm_match_same_cycle", 0, 0, 0, 6, 30);
        tk(6, 29, 59, "pre_match", 0, 0, 0, 6, 30);
        tk(6, 30, 1, "wrong_second", 0, 0, 0, 6, 30);
        tk(6, 30, 0, "ring_start", 1, 1, 0, 6, 30);
        idle("ring_hold_no_tick", 1, 1, 0, 6, 30);

        for (int k = 1; k <= 60; k++)
            tk(12, 0, 6'(k % 60), $sformatf("ring_k%0d", k),
               (k < 60) && (k % 2 == 0), k < 60, 0, 6, 30);
        tk(12, 1, 0, "armed_after_timeout", 0, 0, 0, 6, 30);

        tk(6, 30, 0, "retrigger", 1, 1, 0, 6, 30);
        stop = 1'b1; snooze = 1'b1;
        idle("stop_beats_snooze", 0, 0, 0, 6, 30);

        tk(6, 30, 0, "ring_again", 1, 1, 0, 6, 30);
        set_en = 1'b1; set_hour = 5'd7; set_min = 6'd15;
        idle("load_in_ring", 1, 1, 0, 7, 15);
        set_en = 1'b1; set_hour = 5'd24; set_min = 6'd10;
        idle("bad_hour", 1, 1, 0, 7, 15);
        set_en = 1'b1; set_hour = 5'd3; set_min = 6'd60;
        idle("bad_min", 1, 1, 0, 7, 15);

        snooze = 1'b1;
        idle("snooze_enter", 0, 0, 1, 7, 15);
        snooze = 1'b1;
        idle("snooze_ignored", 0, 0, 1, 7, 15);
        for (int k = 1; k <= 300; k++)
            tk(12, 0, 6'(k % 60), $sformatf("snz_k%0d", k),
               k == 300, k == 300, k < 300, 7, 15);
        tk(12, 5, 1, "rering_tick", 0, 1, 0, 7, 15);
        stop = 1'b1;
        idle("stop_from_ring", 0, 0, 0, 7, 15);

        tk(7, 15, 0, "ring_new_alarm", 1, 1, 0, 7, 15);
        snooze = 1'b1;
        idle("snooze2", 0, 0, 1, 7, 15);
        arm = 1'b0;
        idle("disarm_in_snooze", 0, 0, 0, 7, 15);
        tk(7, 15, 0, "idle_ignores_match", 0, 0, 0, 7, 15);
        arm = 1'b1;
        idle("rearm", 0, 0, 0, 7, 15);
        tk(7, 15, 0, "ring_after_rearm", 1, 1, 0, 7, 15);

        reset = 1'b1;
        idle("reset_mid_ring", 0, 0, 0, 0, 0);
        reset = 1'b0;
        tk(7, 15, 0, "after_reset", 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Downstream consumer of the clock's hour/minute/second counters.
- Holds a programmable alarm time and compares it against the running time on each 1 Hz tick.
- Sequences ring, snooze and stop through an FSM.
- Drives a blinking alarm output (LED/buzzer) and status flags to the top level.

Parameters:
- RING_SECS, 60: ticks the alarm rings before auto-timeout back to ARMED.
- SNOOZE_SECS, 300: ticks spent in SNOOZE before re-ringing.

Ports:
- clk  in  1  system clock (50 MHz domain); all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-clk-wide 1 Hz pulse, coincident with the cycle the time inputs show the new second.
- hour  in  5  current hour, 0..23.
- minute  in  6  current minute, 0..59.
- second  in  6  current second, 0..59.
- set_en  in  1  load alarm time from set_hour/set_min this cycle.
- set_hour  in  5  alarm hour to load.
- set_min  in  6  alarm minute to load.
- arm  in  1  level; 1 = alarm enabled.
- snooze  in  1  one-cycle pulse request.
- stop  in  1  one-cycle pulse request.
- alarm_out  out  1  blinking drive, active while ringing.
- ringing  out  1  state == RINGING.
- snoozing  out  1  state == SNOOZE.
- alarm_hour  out  5  stored alarm hour (for display).
- alarm_min  out  6  stored alarm minute (for display).

Behaviour:
- All outputs registered. Reset values:
  - state IDLE.
  - alarm_hour 0, alarm_min 0.
  - ring_cnt 0, snooze_cnt 0, blink 0.
  - alarm_out 0, ringing 0, snoozing 0.
- Alarm registers:
  - set_en=1 with set_hour<24 and set_min<60 loads both on that edge; visible on alarm_hour/alarm_min next cycle.
  - Out-of-range values are ignored entirely; no partial load.
  - A load is legal in any state and does not change the state.
- match = (hour==alarm_hour) && (minute==alarm_min) && (second==0), evaluated only in cycles with tick=1.
- FSM priority, highest first: reset, arm=0, stop, snooze, tick events.
  - arm=0 in any state: go to IDLE; clear ring_cnt, snooze_cnt, blink.
  - IDLE: arm=1 -> ARMED next cycle. A match in the same cycle as arming is not acted on.
  - ARMED: tick && match -> RINGING; ring_cnt=0, blink=1.
  - RINGING:
    - stop -> ARMED.
    - snooze -> SNOOZE; snooze_cnt=SNOOZE_SECS.
    - Otherwise on tick: ring_cnt+1 and blink toggles.
    - On the tick where ring_cnt+1 == RING_SECS: -> ARMED (timeout).
  - SNOOZE:
    - stop -> ARMED.
    - snooze is ignored.
    - On tick: snooze_cnt-1.
    - On the tick where snooze_cnt==1: -> RINGING; ring_cnt=0, blink=1.
  - stop and snooze in the same cycle: stop wins.
- No re-trigger: a match while in RINGING or SNOOZE is ignored. After a timeout or stop, the alarm fires again at the next day's match only.
- alarm_out = blink while RINGING, else 0. Gives a 0.5 Hz blink starting high on the first ringing second.
- Latency: alarm_out rises one clk after the matching tick cycle.
- Counter widths:
  - ring_cnt: clog2(RING_SECS+1) bits.
  - snooze_cnt: clog2(SNOOZE_SECS+1) bits.
  - Neither counter may wrap.
- Reset asserted mid-ring or mid-snooze returns to IDLE and clears the stored alarm time to 00:00.

Test Plan:
- Reset, then set_en with 06:30, arm=1; drive 06:29:59 then a tick at 06:30:00 -> ringing=1 and alarm_out=1 one clk later; alarm_out toggles on each following tick.
- Ring with no input -> ringing drops on the 60th tick after entry; state ARMED; alarm_out=0.
- Ring, snooze pulse -> snoozing=1; after exactly 300 ticks -> ringing=1 again with alarm_out=1; stop pulse -> ARMED, all flags 0.
- While ringing, stop and snooze in the same cycle -> ARMED, snoozing stays 0. arm=0 while snoozing -> IDLE next cycle.
- set_en with set_hour=24 or set_min=60 -> alarm_hour/alarm_min unchanged. Valid set_en during RINGING -> registers update, ringing stays 1.
- Match at 06:30:00 in the same cycle arm first rises -> no ring. Time at 06:30:01 with alarm 06:30 -> no ring. Reset asserted mid-ring -> all outputs 0 and alarm time 00:00.
